// File: rtl/fb_arb_pkg.sv
// Shared types and framebuffer geometry for the framebuffer port arbiter
// and the scanout address generator.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_SCAN = 2'd1,
        TAG_HOST = 2'd2
    } tag_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_SCAN = 2'd1,
        GNT_WR   = 2'd2,
        GNT_HOST = 2'd3
    } gnt_t;

    localparam int HSIZE    = 640;
    localparam int VSIZE    = 480;
    localparam int FB_WORDS = HSIZE * VSIZE;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fb_rd_tag_pipe.sv
// Read-tag delay line matching the BRAM read latency; the last stage tells
// the arbiter which requester owns the data currently on bram_rdata.
module fb_rd_tag_pipe
    import fb_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic CLK,
    input  logic RESET,
    input  tag_t tag_in,
    output tag_t tag_out
);

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            tag_t tag_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge CLK or posedge RESET) begin
                    if (RESET) tag_reg <= TAG_NONE;
                    else       tag_reg <= tag_in;
                end
            end else begin : g_tail
                always_ff @(posedge CLK or posedge RESET) begin
                    if (RESET) tag_reg <= TAG_NONE;
                    else       tag_reg <= g_stage[gi-1].tag_reg;
                end
            end
        end
    endgenerate

    assign tag_out = g_stage[RD_LAT-1].tag_reg;

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer BRAM arbiter: scanout has absolute priority, writer
// and host share the leftover cycles round-robin; reports starvation stats.
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 31
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_rdata,
    output logic              scan_rvalid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              hrd_valid,
    output logic              hrd_ready,
    input  logic [ADDR_W-1:0] hrd_addr,
    output logic [DATA_W-1:0] hrd_rdata,
    output logic              hrd_rvalid,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    input  logic              starve_clr,
    output logic [1:0]        starve_flag,
    output logic [15:0]       blocked_cnt
);

    localparam int WAIT_W = ($clog2(MAX_WAIT + 1) < 5) ? 5 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    gnt_t        gnt;
    tag_t        tag_in;
    tag_t        tag_last;
    logic        rr_ptr_reg, rr_ptr_next;
    logic [1:0]  starve_reg, starve_next, starve_set;
    logic [15:0] blocked_reg, blocked_next;
    logic [1:0]  req_valid, req_ready;

    // rr_ptr: 0 = writer's turn, 1 = host's turn when both are waiting
    always_comb begin
        gnt = GNT_NONE;
        if (scan_req)                    gnt = GNT_SCAN;
        else if (wr_valid && hrd_valid)  gnt = rr_ptr_reg ? GNT_HOST : GNT_WR;
        else if (wr_valid)               gnt = GNT_WR;
        else if (hrd_valid)              gnt = GNT_HOST;
    end

    always_comb begin
        bram_addr   = '0;
        bram_wdata  = '0;
        tag_in      = TAG_NONE;
        rr_ptr_next = rr_ptr_reg;
        case (gnt)
            GNT_SCAN: begin
                bram_addr = scan_addr;
                tag_in    = TAG_SCAN;
            end
            GNT_WR: begin
                bram_addr   = wr_addr;
                bram_wdata  = wr_data;
                rr_ptr_next = 1'b1;
            end
            GNT_HOST: begin
                bram_addr   = hrd_addr;
                tag_in      = TAG_HOST;
                rr_ptr_next = 1'b0;
            end
            default: ;
        endcase
    end

    assign bram_en   = (gnt != GNT_NONE);
    assign bram_we   = (gnt == GNT_WR);
    assign wr_ready  = (gnt == GNT_WR);
    assign hrd_ready = (gnt == GNT_HOST);

    fb_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .CLK     (CLK),
        .RESET   (RESET),
        .tag_in  (tag_in),
        .tag_out (tag_last)
    );

    assign scan_rvalid = (tag_last == TAG_SCAN);
    assign hrd_rvalid  = (tag_last == TAG_HOST);
    assign scan_rdata  = bram_rdata;
    assign hrd_rdata   = bram_rdata;

    // Bit 0 tracks the writer, bit 1 the host.
    assign req_valid = {hrd_valid, wr_valid};
    assign req_ready = {hrd_ready, wr_ready};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wait
            logic [WAIT_W-1:0] wait_reg, wait_next;

            // Saturating at MAX_WAIT keeps the set condition asserted while starved.
            always_comb begin
                wait_next = '0;
                if (req_valid[gi] && !req_ready[gi])
                    wait_next = (wait_reg == WAIT_MAX) ? wait_reg : wait_reg + WAIT_ONE;
            end

            assign starve_set[gi] = (wait_next == WAIT_MAX);

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) wait_reg <= '0;
                else       wait_reg <= wait_next;
            end
        end
    endgenerate

    assign starve_next  = (starve_clr ? 2'b00 : starve_reg) | starve_set;
    assign blocked_next = (scan_req && (wr_valid || hrd_valid)) ? sat_inc16(blocked_reg)
                                                               : blocked_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rr_ptr_reg  <= 1'b0;
            starve_reg  <= 2'b00;
            blocked_reg <= 16'd0;
        end else begin
            rr_ptr_reg  <= rr_ptr_next;
            starve_reg  <= starve_next;
            blocked_reg <= blocked_next;
        end
    end

    assign starve_flag = starve_reg;
    assign blocked_cnt = blocked_reg;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter (RD_LAT=2): table vectors, directed corner
// sequences, and a randomized run against a behavioural model.
module tb_fb_port_arbiter;

    localparam int TB_LAT   = 2;
    localparam int MAX_WAIT = 31;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        scan_req;
    logic [18:0] scan_addr;
    logic [15:0] scan_rdata;
    logic        scan_rvalid;
    logic        wr_valid, wr_ready;
    logic [18:0] wr_addr;
    logic [15:0] wr_data;
    logic        hrd_valid, hrd_ready;
    logic [18:0] hrd_addr;
    logic [15:0] hrd_rdata;
    logic        hrd_rvalid;
    logic        bram_en, bram_we;
    logic [18:0] bram_addr;
    logic [15:0] bram_wdata, bram_rdata;
    logic        starve_clr;
    logic [1:0]  starve_flag;
    logic [15:0] blocked_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    fb_port_arbiter #(
        .ADDR_W (19), .DATA_W (16), .RD_LAT (TB_LAT), .MAX_WAIT (MAX_WAIT)
    ) dut (
        .CLK (CLK), .RESET (RESET),
        .scan_req (scan_req), .scan_addr (scan_addr),
        .scan_rdata (scan_rdata), .scan_rvalid (scan_rvalid),
        .wr_valid (wr_valid), .wr_ready (wr_ready),
        .wr_addr (wr_addr), .wr_data (wr_data),
        .hrd_valid (hrd_valid), .hrd_ready (hrd_ready),
        .hrd_addr (hrd_addr), .hrd_rdata (hrd_rdata), .hrd_rvalid (hrd_rvalid),
        .bram_en (bram_en), .bram_we (bram_we),
        .bram_addr (bram_addr), .bram_wdata (bram_wdata), .bram_rdata (bram_rdata),
        .starve_clr (starve_clr), .starve_flag (starve_flag), .blocked_cnt (blocked_cnt)
    );

    // Framebuffer BRAM stand-in with TB_LAT registered read stages.
    logic [15:0] mem [256];
    logic [15:0] rd_pipe [2];
    logic        mem_clr;
    int          we_pulses = 0;

    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'd0;
        end else if (bram_en && bram_we) begin
            mem[bram_addr[7:0]] <= bram_wdata;
        end
        rd_pipe[0] <= mem[bram_addr[7:0]];
        rd_pipe[1] <= rd_pipe[0];
        if (!RESET && bram_we) we_pulses <= we_pulses + 1;
    end
    assign bram_rdata = rd_pipe[TB_LAT-1];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        scan_req = 0; scan_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
        hrd_valid = 0; hrd_addr = '0; starve_clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b1;
        mem_clr = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        mem_clr = 1'b0;
    endtask

    typedef struct {
        logic s, w, h;
        logic e_wr, e_hr, e_en, e_we;
        logic [18:0] e_addr;
    } vec_t;

    typedef struct {
        int          due;
        int          who;
        logic [15:0] data;
    } ret_t;

    vec_t        vt [9];
    ret_t        pend_q [$];
    logic [15:0] model_mem [256];

    initial begin
        int   bad, bad2, we0, win, m_turn_host, m_blocked;
        int   m_wait [2];
        logic [1:0] m_flag, flag_new;
        logic [5:0] wpat, hpat;
        logic wv_hold, hv_hold, exp_s, exp_h;
        logic [15:0] exp_d;
        ret_t r;

        idle_inputs();
        RESET = 1'b1;
        mem_clr = 1'b1;
        for (int i = 0; i < 256; i++) model_mem[i] = 16'd0;

        // ---- reset state
        @(negedge CLK); #1;
        check("rst_wr_ready", wr_ready, 0);
        check("rst_hrd_ready", hrd_ready, 0);
        check("rst_rvalid", {scan_rvalid, hrd_rvalid}, 0);
        check("rst_starve_flag", starve_flag, 0);
        check("rst_blocked_cnt", blocked_cnt, 0);
        do_reset();

        // ---- table vectors (consecutive from reset; rr_ptr starts at writer)
        vt[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 19'h011};
        vt[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 19'h022};
        vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 19'h033};
        vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 19'h033};
        vt[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 19'h022};
        vt[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 19'h022};
        vt[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 19'h033};
        vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 19'h000};
        vt[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 19'h011};
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            scan_req = vt[i].s; wr_valid = vt[i].w; hrd_valid = vt[i].h;
            scan_addr = 19'h011; wr_addr = 19'h022; hrd_addr = 19'h033; wr_data = 16'hABCD;
            #1;
            check("vec_wr_ready", wr_ready, vt[i].e_wr);
            check("vec_hrd_ready", hrd_ready, vt[i].e_hr);
            check("vec_bram_en", bram_en, vt[i].e_en);
            check("vec_bram_we", bram_we, vt[i].e_we);
            check("vec_bram_addr", bram_addr, vt[i].e_addr);
            check("vec_bram_wdata", bram_wdata, vt[i].e_we ? 32'hABCD : 32'h0);
            $display("vec %0d: scan=%0b wr=%0b hrd=%0b -> wr_ready=%0b hrd_ready=%0b addr=0x%0h",
                     i, vt[i].s, vt[i].w, vt[i].h, wr_ready, hrd_ready, bram_addr);
        end
        @(negedge CLK); idle_inputs(); #1;
        check("vec_blocked_cnt", blocked_cnt, 1);

        // ---- single write then host read
        do_reset();
        we0 = we_pulses;
        @(negedge CLK); wr_valid = 1; wr_addr = 19'h00010; wr_data = 16'hF800; #1;
        check("wr_ready", wr_ready, 1);
        check("wr_bram_we", bram_we, 1);
        @(negedge CLK); wr_valid = 0; hrd_valid = 1; hrd_addr = 19'h00010; #1;
        check("hrd_ready", hrd_ready, 1);
        @(negedge CLK); hrd_valid = 0; #1;
        check("hrd_rvalid_t1", hrd_rvalid, 0);
        @(negedge CLK); #1;
        check("hrd_rvalid_t2", hrd_rvalid, 1);
        check("hrd_rdata", hrd_rdata, 16'hF800);
        @(negedge CLK); #1;
        check("hrd_rvalid_t3", hrd_rvalid, 0);
        check("we_pulse_count", we_pulses - we0, 1);
        $display("seq write/read: hrd_rdata=0x%0h", 16'hF800);

        // ---- scanout priority
        do_reset();
        bad = 0;
        for (int i = 0; i < 640; i++) begin
            @(negedge CLK); scan_req = 1; scan_addr = 19'(i); wr_valid = 1; wr_addr = 19'h5; #1;
            if (wr_ready !== 1'b0) bad++;
        end
        check("scan_prio_wr_ready_cycles", bad, 0);
        @(negedge CLK); scan_req = 0; #1;
        check("scan_prio_wr_ready_after", wr_ready, 1);
        check("scan_prio_blocked_cnt", blocked_cnt, 640);
        $display("seq scan priority: blocked_cnt=%0d", blocked_cnt);

        // ---- round-robin
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK); wr_valid = 1; hrd_valid = 1; #1;
            wpat[i] = wr_ready; hpat[i] = hrd_ready;
        end
        check("rr_writer_pattern", wpat, 6'b010101);
        check("rr_host_pattern", hpat, 6'b101010);
        $display("seq round-robin: wr=%b hrd=%b", wpat, hpat);

        // ---- tag routing, alternating scan / host reads
        do_reset();
        bad = 0; bad2 = 0; we0 = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            scan_req  = (i < 10) && (i % 2 == 0);
            hrd_valid = (i < 10) && (i % 2 == 1);
            hrd_addr  = 19'h33;
            #1;
            if (scan_rvalid && hrd_rvalid) we0++;
            if (scan_rvalid !== ((i >= 2) && (i - 2 < 10) && ((i - 2) % 2 == 0))) bad++;
            if (hrd_rvalid  !== ((i >= 2) && (i - 2 < 10) && ((i - 2) % 2 == 1))) bad2++;
        end
        check("tag_both_rvalid", we0, 0);
        check("tag_scan_rvalid_timing", bad, 0);
        check("tag_hrd_rvalid_timing", bad2, 0);
        $display("seq tag routing: 5 scan + 5 host reads");

        // ---- starvation
        do_reset();
        bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK); scan_req = 1; hrd_valid = 1; #1;
            if (starve_flag !== ((k >= 32) ? 2'b10 : 2'b00)) bad++;
        end
        check("starve_flag_timing", bad, 0);
        @(negedge CLK); scan_req = 0; #1;
        check("starve_hrd_ready", hrd_ready, 1);
        check("starve_blocked_cnt", blocked_cnt, 40);
        @(negedge CLK); hrd_valid = 0; #1;
        check("starve_flag_sticky", starve_flag, 2'b10);
        @(negedge CLK); starve_clr = 1; #1;
        @(negedge CLK); starve_clr = 0; #1;
        check("starve_flag_cleared", starve_flag, 2'b00);
        $display("seq starvation: flag set and cleared");

        // ---- reset one cycle after a host read grant
        do_reset();
        @(negedge CLK); hrd_valid = 1; hrd_addr = 19'h10; #1;
        check("rst_mid_hrd_ready", hrd_ready, 1);
        @(negedge CLK); hrd_valid = 0; wr_valid = 1; #1;
        check("rst_mid_wr_ready", wr_ready, 1);
        #2; RESET = 1; idle_inputs(); #1;
        check("rst_mid_rvalid", {scan_rvalid, hrd_rvalid}, 0);
        check("rst_mid_ready", {wr_ready, hrd_ready}, 0);
        check("rst_mid_flags", starve_flag, 0);
        check("rst_mid_blocked", blocked_cnt, 0);
        @(negedge CLK); @(negedge CLK); RESET = 0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK); #1;
            if (hrd_rvalid !== 1'b0 || scan_rvalid !== 1'b0) bad++;
        end
        check("rst_mid_no_rvalid", bad, 0);
        @(negedge CLK); wr_valid = 1; hrd_valid = 1; #1;
        check("rst_mid_rr_ptr", {wr_ready, hrd_ready}, 2'b10);
        $display("seq reset mid-read: in-flight tag dropped");

        // ---- randomized run against the behavioural model
        do_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = 16'd0;
        pend_q.delete();
        m_turn_host = 0; m_blocked = 0; m_wait[0] = 0; m_wait[1] = 0; m_flag = 2'b00;
        wv_hold = 0; hv_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            scan_req  = ($urandom_range(0, 99) < 35);
            scan_addr = 19'($urandom_range(0, 255));
            if (!wv_hold) begin
                wr_valid = 1'($urandom_range(0, 1));
                wr_addr  = 19'($urandom_range(0, 255));
                wr_data  = 16'($urandom);
            end
            if (!hv_hold) begin
                hrd_valid = 1'($urandom_range(0, 1));
                hrd_addr  = 19'($urandom_range(0, 255));
            end
            starve_clr = ($urandom_range(0, 39) == 0);
            #1;
            if (scan_req)                   win = 1;
            else if (wr_valid && hrd_valid) win = m_turn_host ? 3 : 2;
            else if (wr_valid)              win = 2;
            else if (hrd_valid)             win = 3;
            else                            win = 0;

            check("rnd_wr_ready", wr_ready, win == 2);
            check("rnd_hrd_ready", hrd_ready, win == 3);
            check("rnd_bram_en", bram_en, win != 0);
            check("rnd_bram_we", bram_we, win == 2);
            check("rnd_bram_addr", bram_addr,
                  (win == 1) ? scan_addr : (win == 2) ? wr_addr : (win == 3) ? hrd_addr : 19'd0);
            check("rnd_bram_wdata", bram_wdata, (win == 2) ? wr_data : 16'd0);

            exp_s = 0; exp_h = 0; exp_d = '0;
            if (pend_q.size() > 0 && pend_q[0].due == c) begin
                r = pend_q.pop_front();
                exp_s = (r.who == 1); exp_h = (r.who == 3); exp_d = r.data;
            end
            check("rnd_scan_rvalid", scan_rvalid, exp_s);
            check("rnd_hrd_rvalid", hrd_rvalid, exp_h);
            if (exp_s) check("rnd_scan_rdata", scan_rdata, exp_d);
            if (exp_h) check("rnd_hrd_rdata", hrd_rdata, exp_d);
            check("rnd_starve_flag", starve_flag, m_flag);
            check("rnd_blocked_cnt", blocked_cnt, m_blocked);

            case (win)
                1: pend_q.push_back('{c + TB_LAT, 1, model_mem[scan_addr[7:0]]});
                2: begin model_mem[wr_addr[7:0]] = wr_data; m_turn_host = 1; end
                3: begin pend_q.push_back('{c + TB_LAT, 3, model_mem[hrd_addr[7:0]]}); m_turn_host = 0; end
                default: ;
            endcase
            m_wait[0] = (wr_valid  && win != 2) ? m_wait[0] + 1 : 0;
            m_wait[1] = (hrd_valid && win != 3) ? m_wait[1] + 1 : 0;
            flag_new = starve_clr ? 2'b00 : m_flag;
            if (m_wait[0] >= MAX_WAIT) flag_new[0] = 1'b1;
            if (m_wait[1] >= MAX_WAIT) flag_new[1] = 1'b1;
            m_flag = flag_new;
            if (scan_req && (wr_valid || hrd_valid) && m_blocked < 65535) m_blocked++;
            wv_hold = wr_valid  && (win != 2);
            hv_hold = hrd_valid && (win != 3);
        end
        $display("seq random: 3000 cycles, blocked_cnt model=%0d", m_blocked);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
